// File: rtl/clock_display_pkg.sv
// Shared constants for the multiplexed 7-segment clock display.
// Segment codes are active-high with bit order {g,f,e,d,c,b,a}.
package clock_display_pkg;

  localparam logic [1:0] DIG_LS_MIN = 2'd0;
  localparam logic [1:0] DIG_MS_MIN = 2'd1;
  localparam logic [1:0] DIG_LS_HR  = 2'd2;
  localparam logic [1:0] DIG_MS_HR  = 2'd3;

  // Entry 0 is the least significant slice, so digit 9 is listed first.
  localparam logic [9:0][6:0] SEG_CODE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder.
// Non-BCD values 10-15 decode to a dash so bad input stays visible.
module bcd_to_seg7
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) seg_o = SEG_CODE[bcd_i];
  end

endmodule

// File: rtl/clock_display_scan.sv
// Scans four hh:mm BCD digits onto a common-anode multiplexed display with a
// per-frame time snapshot and blinking colon. Optional: LEADING_ZERO_BLANK_EN.
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 125,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] time_ms_hr,
  input  logic [3:0] time_ls_hr,
  input  logic [2:0] time_ms_min,
  input  logic [3:0] time_ls_min,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic [PW-1:0]      pre_q, pre_d;
  logic [1:0]         idx_q, idx_d;
  logic [FW-1:0]      frm_q, frm_d;
  logic               colon_q, colon_d;
  logic [3:0][3:0]    shadow_q, shadow_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               tick, frame_end;
  logic [3:0]         an_h;
  logic [6:0]         seg_h, cur_seg;
  logic               dp_h;

  bcd_to_seg7 u_dec (
    .bcd_i (shadow_q[idx_q]),
    .seg_o (cur_seg)
  );

  // Scan timing, frame snapshot and colon blink.
  always_comb begin
    tick      = (pre_q == PRE_LAST);
    frame_end = tick && (idx_q == DIG_MS_HR);
    pre_d     = tick ? '0 : pre_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    frm_d     = frm_q;
    colon_d   = colon_q;
    if (frame_end) begin
      shadow_d = {{2'b00, time_ms_hr}, time_ls_hr, {1'b0, time_ms_min}, time_ls_min};
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        colon_d = ~colon_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Output drive is computed active-high, then folded to the panel polarity.
  always_comb begin
    an_h  = 4'b0001 << idx_q;
    seg_h = cur_seg;
    dp_h  = (idx_q == DIG_LS_HR) && colon_q;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == DIG_MS_HR) && (shadow_q[DIG_MS_HR] == 4'd0)) begin
      an_h  = 4'b0000;
      seg_h = SEG_BLANK;
    end
`endif
    if (!en) begin
      an_h  = 4'b0000;
      seg_h = SEG_BLANK;
      dp_h  = 1'b0;
    end
    an_d  = SEG_ACTIVE_LOW ? ~an_h  : an_h;
    seg_d = SEG_ACTIVE_LOW ? ~seg_h : seg_h;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_h  : dp_h;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      idx_q    <= 2'd0;
      frm_q    <= '0;
      colon_q  <= 1'b1;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      colon_q  <= colon_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan (SCAN_DIV=4, BLINK_FRAMES=2,
// active-low); expected {an,seg,dp} come from a cycle-count based model.
module tb_clock_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam logic [11:0] ALL_OFF = 12'hFFF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [1:0] time_ms_hr  = 2'd1;
  logic [3:0] time_ls_hr  = 4'd2;
  logic [2:0] time_ms_min = 3'd3;
  logic [3:0] time_ls_min = 4'd4;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  clock_display_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .time_ms_hr  (time_ms_hr),
    .time_ls_hr  (time_ls_hr),
    .time_ms_min (time_ms_min),
    .time_ls_min (time_ls_min),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clock = ~clock;

  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [3:0]  sh [4];

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               tag, cyc, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  function automatic logic [6:0] ref_code(input logic [3:0] v);
    case (v)
      4'd0: ref_code = 7'h3F;
      4'd1: ref_code = 7'h06;
      4'd2: ref_code = 7'h5B;
      4'd3: ref_code = 7'h4F;
      4'd4: ref_code = 7'h66;
      4'd5: ref_code = 7'h6D;
      4'd6: ref_code = 7'h7D;
      4'd7: ref_code = 7'h07;
      4'd8: ref_code = 7'h7F;
      4'd9: ref_code = 7'h6F;
      default: ref_code = 7'h40;
    endcase
  endfunction

  // c = clock edges since reset release before the edge being predicted.
  function automatic logic [11:0] ref_out(input int c, input logic e);
    int         slot;
    int         frame;
    logic       colon;
    logic [3:0] an_h;
    logic [6:0] seg_h;
    logic       dp_h;
    slot  = (c / SCAN_DIV) % 4;
    frame = c / FRAME;
    colon = ((frame / BLINK_FRAMES) % 2) == 0;
    an_h  = 4'b0001 << slot;
    seg_h = ref_code(sh[slot]);
    dp_h  = (slot == 2) && colon;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && sh[3] == 4'd0) begin
      an_h  = 4'b0000;
      seg_h = 7'h00;
    end
`endif
    if (!e) return ALL_OFF;
    return ~{an_h, seg_h, dp_h};
  endfunction

  // Called at posedge+1: predict the next edge, clock it, then compare.
  task automatic step(input string tag);
    logic       boundary;
    logic [3:0] cap [4];
    exp_q.push_back(ref_out(cyc, en));
    boundary = (cyc % FRAME) == (FRAME - 1);
    cap[0] = time_ls_min;
    cap[1] = {1'b0, time_ms_min};
    cap[2] = time_ls_hr;
    cap[3] = {2'b00, time_ms_hr};
    @(posedge clock);
    #1;
    if (boundary) for (int i = 0; i < 4; i++) sh[i] = cap[i];
    cyc++;
    check(tag, {an, seg, dp}, exp_q.pop_front());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_to_phase(input int phase, input string tag);
    while ((cyc % FRAME) != phase) step(tag);
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_hold", {an, seg, dp}, ALL_OFF);
    en = 1'b1;
    @(posedge clock);
    #1;
    check("reset_edge", {an, seg, dp}, ALL_OFF);
    reset = 1'b0;
    model_reset();

    run(3 * FRAME, "scan_1234");

    run_to_phase(2, "pre_change");
    time_ls_min = 4'd5;
    run(2 * FRAME, "ls_min_change");

    time_ls_hr = 4'hC;
    run(2 * FRAME, "illegal_dash");
    time_ls_hr = 4'd2;

    run_to_phase(6, "pre_en");
    en = 1'b0;
    run(5, "en_off");
    en = 1'b1;
    run(2 * FRAME, "en_resume");

    run_to_phase(FRAME - 1, "pre_boundary");
    time_ms_min = 3'd0;
    run(2 * FRAME, "boundary_capture");

    for (int k = 0; k < 25; k++) begin
      time_ms_hr  = 2'($urandom_range(0, 2));
      time_ls_hr  = 4'($urandom_range(0, 15));
      time_ms_min = 3'($urandom_range(0, 7));
      time_ls_min = 4'($urandom_range(0, 9));
      en          = ($urandom_range(0, 5) != 0);
      run($urandom_range(1, 20), "random");
    end
    en = 1'b1;
    run(FRAME, "random_tail");

    run_to_phase(5, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", {an, seg, dp}, ALL_OFF);
    @(posedge clock);
    #1;
    check("reset_mid_hold", {an, seg, dp}, ALL_OFF);
    reset = 1'b0;
    model_reset();

    time_ms_hr  = 2'd0;
    time_ls_hr  = 4'd9;
    time_ms_min = 3'd4;
    time_ls_min = 4'd5;
    run(7 * FRAME, "time_0945");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
